// File: rtl/mpr121_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mpr121_pkg
//  Description : Shared state encoding and register map of the MPR121
//                register-level emulation.
//  Revision    : 1.0 - initial release
// ============================================================================
package mpr121_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } resp_state_t;

    localparam logic [7:0] REG_TOUCH_L     = 8'h00;
    localparam logic [7:0] REG_TOUCH_H     = 8'h01;
    localparam logic [7:0] REG_THRESH_BASE = 8'h41;
    localparam logic [7:0] REG_THRESH_LAST = 8'h58;
    localparam logic [7:0] REG_CONFIG2     = 8'h5D;
    localparam logic [7:0] REG_ECR         = 8'h5E;

    // True for the 24 threshold byte addresses
    function automatic logic is_thresh(input logic [7:0] a);
        return (a >= REG_THRESH_BASE) && (a <= REG_THRESH_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpr121_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mpr121_responder_if
//  Description : Pad, touch input and write-observation signals of the
//                MPR121 responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mpr121_responder_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [11:0] touch_in;
    logic [7:0]  ecr_out;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    modport slave (
        input  scl_in, sda_in, touch_in,
        output sda_oe, ecr_out, wr_valid, wr_addr, wr_data, busy
    );

    modport master (
        output scl_in, sda_in, touch_in,
        input  sda_oe, ecr_out, wr_valid, wr_addr, wr_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sync
//  Description : Two-flop synchronizers on SCL/SDA plus edge, START and
//                STOP strobes derived from the synchronized lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic i_scl,
    input  wire logic i_sda,
    output logic      o_sda,
    output logic      o_scl_rise,
    output logic      o_scl_fall,
    output logic      o_start,
    output logic      o_stop
);
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;

    // Synchronize the pads and keep the previous synced value; reset to idle bus
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = w_scl & r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & ~r_sda_prev & w_sda;
endmodule
`default_nettype wire

// File: rtl/mpr121_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mpr121_responder
//  Description : I2C target emulating the MPR121 register file with a live
//                12-bit touch status.
//  Revision    : 1.0 - initial release
// ============================================================================
module mpr121_responder
    import mpr121_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h5A,
    parameter logic [7:0] CONFIG2_RST = 8'h24
) (
    input  wire logic           clk_in,
    input  wire logic           rst_in,
    mpr121_responder_if.slave   bus
);
    resp_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic [7:0]  r_shift;
    logic        r_rw;
    logic [7:0]  r_ptr;
    logic [7:0]  r_thresh [24];
    logic [7:0]  r_config2;
    logic [7:0]  r_ecr;
    logic        r_sda_oe;
    logic        r_wr_valid;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_busy;

    logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_shift_in;
    logic        w_match, w_bit_rise, w_last_rise, w_byte_end;
    logic [11:0] w_touch;
    logic [4:0]  w_thr_idx;
    logic [7:0]  w_rd_byte;
    logic        w_is_wr;
    logic        w_sda_oe_nxt, w_load, w_commit;

    i2c_bus_sync u_sync (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_scl      (bus.scl_in),
        .i_sda      (bus.sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_shift_in  = {r_shift[6:0], w_sda};
    assign w_match     = (w_shift_in[7:1] == ADDR);
    assign w_bit_rise  = w_scl_rise && (r_cnt != 4'd8);
    assign w_last_rise = w_scl_rise && (r_cnt == 4'd7);
    assign w_byte_end  = w_scl_fall && (r_cnt == 4'd8);
    assign w_touch     = (r_ecr[5:0] != 6'd0) ? bus.touch_in : 12'h000;
    // Threshold slot index; only meaningful when the pointer is in range
    assign w_thr_idx   = r_ptr[4:0] - REG_THRESH_BASE[4:0];
    assign w_is_wr     = is_thresh(r_ptr) || (r_ptr == REG_CONFIG2) || (r_ptr == REG_ECR);

    // Read data for the byte at the current pointer
    always_comb begin
        w_rd_byte = 8'h00;
        if (r_ptr == REG_TOUCH_L)      w_rd_byte = w_touch[7:0];
        else if (r_ptr == REG_TOUCH_H) w_rd_byte = {4'h0, w_touch[11:8]};
        else if (is_thresh(r_ptr))     w_rd_byte = r_thresh[w_thr_idx];
        else if (r_ptr == REG_CONFIG2) w_rd_byte = r_config2;
        else if (r_ptr == REG_ECR)     w_rd_byte = r_ecr;
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; bus conditions override any bit activity
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_last_rise && !w_match) w_state_nxt = ST_IDLE;
                    else if (w_byte_end)         w_state_nxt = ST_ADDR_ACK;
                end
                ST_ADDR_ACK:  if (w_scl_fall) w_state_nxt = r_rw ? ST_RDATA : ST_REG;
                ST_REG:       if (w_byte_end) w_state_nxt = ST_REG_ACK;
                ST_REG_ACK:   if (w_scl_fall) w_state_nxt = ST_WDATA;
                ST_WDATA:     if (w_byte_end) w_state_nxt = ST_WDATA_ACK;
                ST_WDATA_ACK: if (w_scl_fall) w_state_nxt = ST_WDATA;
                ST_RDATA:     if (w_byte_end) w_state_nxt = ST_RDATA_ACK;
                ST_RDATA_ACK: if (w_scl_fall) w_state_nxt = r_shift[0] ? ST_IDLE : ST_RDATA;
                default:      w_state_nxt = r_state;
            endcase
        end
    end

    // Output decode: next SDA drive, read-byte load and write commit strobes
    always_comb begin
        w_sda_oe_nxt = r_sda_oe;
        w_load       = 1'b0;
        if (w_start || w_stop) begin
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_REG, ST_WDATA: if (w_byte_end) w_sda_oe_nxt = 1'b1;
                ST_ADDR_ACK: if (w_scl_fall) begin
                    w_load       = r_rw;
                    w_sda_oe_nxt = r_rw & ~w_rd_byte[7];
                end
                ST_REG_ACK, ST_WDATA_ACK: if (w_scl_fall) w_sda_oe_nxt = 1'b0;
                ST_RDATA: if (w_scl_fall) w_sda_oe_nxt = (r_cnt == 4'd8) ? 1'b0 : ~r_shift[6];
                ST_RDATA_ACK: if (w_scl_fall) begin
                    w_load       = ~r_shift[0];
                    w_sda_oe_nxt = ~r_shift[0] & ~w_rd_byte[7];
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
        w_commit = (r_state == ST_WDATA) && w_last_rise && !w_start && !w_stop;
    end

    // Datapath: shifting, bit count, pointer, register file and outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_ptr      <= 8'h00;
            r_config2  <= CONFIG2_RST;
            r_ecr      <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
            r_busy     <= 1'b0;
            for (int i = 0; i < 24; i++) r_thresh[i] <= 8'h00;
        end else begin
            r_sda_oe   <= w_sda_oe_nxt;
            r_wr_valid <= 1'b0;
            if (w_start || w_stop) begin
                r_cnt <= 4'd0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_REG, ST_WDATA: if (w_bit_rise) begin
                        r_shift <= w_shift_in;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                    ST_RDATA: begin
                        if (w_bit_rise) r_cnt <= r_cnt + 4'd1;
                        else if (w_scl_fall) begin
                            if (r_cnt == 4'd8) r_cnt <= 4'd0;
                            else               r_shift <= {r_shift[6:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: if (w_scl_rise) r_shift <= w_shift_in;
                    default: ;
                endcase
                if ((r_state == ST_ADDR_ACK || r_state == ST_REG_ACK ||
                     r_state == ST_WDATA_ACK || r_state == ST_RDATA_ACK) && w_scl_fall)
                    r_cnt <= 4'd0;
                if (r_state == ST_ADDR && w_last_rise) begin
                    r_rw <= w_sda;
                    if (w_match) r_busy <= 1'b1;
                end
                if (r_state == ST_REG && w_last_rise) r_ptr <= w_shift_in;
                if (w_commit) begin
                    r_ptr <= r_ptr + 8'd1;
                    if (w_is_wr) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_ptr;
                        r_wr_data  <= w_shift_in;
                        if (is_thresh(r_ptr))          r_thresh[w_thr_idx] <= w_shift_in;
                        else if (r_ptr == REG_CONFIG2) r_config2 <= w_shift_in;
                        else                           r_ecr <= w_shift_in;
                    end
                end
                if (w_load) begin
                    r_shift <= w_rd_byte;
                    r_ptr   <= r_ptr + 8'd1;
                end
            end
            if (w_stop) r_busy <= 1'b0;
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.ecr_out  = r_ecr;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
endmodule
`default_nettype wire

// File: doc/mpr121_responder.md
# mpr121_responder

I2C target that emulates the register-level behaviour of an MPR121 capacitive touch sensor. It lets `mpr121_controller` and the I2C initiator be exercised on the board or in simulation without the physical sensor. It decodes START, address, register pointer, write data, repeated-START and read phases on oversampled SCL/SDA. It serves a small register file plus a live 12-bit touch status driven from board inputs.

## Interface
Parameters:
- `ADDR`, 7'h5A, 7-bit target address that this block ACKs.
- `CONFIG2_RST`, 8'h24, reset value of register 0x5D.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`  input  1  system clock; must be at least 16x the SCL frequency.
- `rst_in`  input  1  synchronous active-high reset.
- `scl_in`  input  1  raw SCL from the pad; asynchronous.
- `sda_in`  input  1  raw SDA from the pad; asynchronous.
- `sda_oe`  output  1  1 = pull SDA low (open-drain); 0 = release.
- `touch_in`  input  12  live electrode states; bit n is electrode n.
- `ecr_out`  output  8  current ECR (0x5E) contents.
- `wr_valid`  output  1  one-cycle pulse when a data byte is committed by a write.
- `wr_addr`  output  8  register address of the committed byte; valid with `wr_valid`.
- `wr_data`  output  8  committed byte; valid with `wr_valid`.
- `busy`  output  1  high from an addressed START until STOP.

## Operation
- Input conditioning: 2-flop synchronizers on SCL and SDA, then a registered previous value for edge detection.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high.
- Bits are sampled on SCL rising edges, MSB first. SDA is changed only after an SCL falling edge.
- Register map:
  - 0x00: touch_status[7:0] (read-only).
  - 0x01: {4'b0, touch_status[11:8]} (read-only).
  - 0x41–0x58: 24 threshold bytes (read/write), reset 0x00.
  - 0x5D: CONFIG2 (read/write), reset `CONFIG2_RST`.
  - 0x5E: ECR (read/write), reset 0x00.
  - All other addresses read 0x00; writes to them are ACKed and discarded, with no `wr_valid`.
- Touch status: equals `touch_in` when ECR[5:0] != 0, otherwise 0. It is snapshotted into the shift register at the SCL falling edge that begins each read byte.
- Register pointer: auto-increments after every data byte, read or write. It wraps from 0xFF to 0x00.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - IDLE: START -> ADDR.
  - ADDR: after 8 bits, compare the 7-bit address.
    - Match -> ADDR_ACK.
    - Mismatch -> IDLE; SDA is never driven.
    - R/W bit 1 -> read path; R/W bit 0 -> write path.
  - ADDR_ACK:
    - Write -> REG.
    - Read -> RDATA, starting at the current pointer.
  - REG: latch the pointer -> REG_ACK -> WDATA.
  - WDATA: 8 bits -> commit the byte, pulse `wr_valid` -> WDATA_ACK -> WDATA.
  - RDATA: drive the byte -> RDATA_ACK, which samples the initiator's bit.
    - ACK (0) -> RDATA with the next byte.
    - NACK (1) -> IDLE with SDA released.
- START in any state (repeated START) -> ADDR; the pointer is kept. STOP in any state -> IDLE.

## Timing
- Synchronizer plus edge detect: 3 `clk_in` cycles from a pad edge to an internal event.
- ACK: `sda_oe` rises 1 cycle after the detected SCL falling edge that ends bit 8. It falls 1 cycle after the next detected SCL falling edge.
- Read bits: `sda_oe` = ~bit, updated 1 cycle after each detected SCL falling edge.
- `wr_valid`: pulses exactly 1 cycle, on the cycle after the 8th data-bit rising-edge sample. `ecr_out` and register contents update in that same cycle.
- Simultaneous START/STOP and SCL edge in one cycle: START/STOP takes priority; the bit is discarded.
- Reset values:
  - `sda_oe` = 0, `busy` = 0, `wr_valid` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `ecr_out` = 0x00; pointer = 0x00; FSM = IDLE; registers at reset values.
- Reset mid-transfer releases SDA on the next cycle. The block ignores the bus until the next START.

## Structure
- `mpr121_pkg` holds:
  - State enum `resp_state_t`.
  - Constants `REG_TOUCH_L` = 0x00, `REG_TOUCH_H` = 0x01, `REG_THRESH_BASE` = 0x41, `REG_THRESH_LAST` = 0x58, `REG_CONFIG2` = 0x5D, `REG_ECR` = 0x5E.
- `mpr121_controller` should also adopt these constants.
- One sub-module, `i2c_bus_sync`: synchronizers plus scl_rise, scl_fall, start and stop strobes.

## Test plan
- Write 0x5A+W, reg 0x5E, data 0x0C, STOP -> all three bytes ACKed; `wr_valid` with `wr_addr`=0x5E and `wr_data`=0x0C; `ecr_out`=0x0C.
- Write reg 0x5D, repeated START, 0x5A+R, NACK -> reads 0x24.
- ECR=0x0C and `touch_in`=12'hA53; read from reg 0x00 with ACK then NACK -> reads 0x53 then 0x0A. Same with ECR=0 -> reads 0x00 and 0x00.
- Burst write 24 bytes starting at 0x41, then burst read them back -> identical data; `wr_addr` steps 0x41..0x58.
- Address 0x5B -> `sda_oe` stays 0 for the whole transaction; `busy` stays 0.
- `rst_in` asserted during RDATA while driving a 0 -> `sda_oe`=0 next cycle; a following transaction completes normally.
